// File: rtl/renderer_pkg.sv
// Shared renderer types: the block table entry layout, block attribute enums,
// scheduler FSM states and the 13-bit footprint overlap test.
package renderer_pkg;

  localparam int BLOCK_HALF_DEF = 32;

  typedef enum logic [2:0] {
    UP    = 3'd0,
    RIGHT = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    ANY   = 3'd4
  } direction_t;

  typedef enum logic {
    BLUE = 1'b0,
    RED  = 1'b1
  } color_t;

  // Bit layout matches tbl_data_in, MSB first.
  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [13:0] z;
    color_t      color;
    direction_t  dir;
    logic        visible;
  } block_entry_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2
  } scan_state_t;

  // |p - c| <= half, written without subtraction so nothing can underflow.
  function automatic logic span_hit(input logic [12:0] p, input logic [12:0] c,
                                    input logic [12:0] half);
    return ((p + half) >= c) && (p <= (c + half));
  endfunction

endpackage

// File: rtl/block_line_scheduler_zmin_select.sv
// Minimum-z pick among the hitting slots. Pairwise reduction tree; a right
// child only replaces its left sibling when strictly nearer, so equal z
// always resolves to the lower slot index.
module zmin_select #(
  parameter int SLOTS = 4,
  parameter int ZW    = 14,
  parameter int IW    = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic [SLOTS-1:0]         hit,
  input  logic [SLOTS-1:0][ZW-1:0] z,
  output logic [IW-1:0]            win_idx,
  output logic                     any_hit
);

  localparam int LEVELS = (SLOTS > 1) ? $clog2(SLOTS) : 0;
  localparam int P      = 1 << LEVELS;

  logic [P-1:0]         n_vld;
  logic [P-1:0][ZW-1:0] n_z;
  logic [P-1:0][IW-1:0] n_idx;

  // Leaves padded to a power of two, then reduce pairs level by level into node 0.
  always_comb begin
    n_vld = '0;
    n_z   = '0;
    n_idx = '0;
    for (int i = 0; i < SLOTS; i++) begin
      n_vld[i] = hit[i];
      n_z[i]   = z[i];
      n_idx[i] = IW'(i);
    end
    for (int l = 0; l < LEVELS; l++) begin
      for (int i = 0; i < P; i += (2 << l)) begin
        if (n_vld[i + (1 << l)] && (!n_vld[i] || (n_z[i + (1 << l)] < n_z[i]))) begin
          n_vld[i] = 1'b1;
          n_z[i]   = n_z[i + (1 << l)];
          n_idx[i] = n_idx[i + (1 << l)];
        end
      end
    end
    win_idx = n_idx[0];
    any_hit = n_vld[0];
  end

endmodule

// File: rtl/block_line_scheduler.sv
// Scanline scheduler: builds a per-line list of up to SLOTS blocks during
// hblank, then picks the nearest covering block for every active pixel.
module block_line_scheduler
  import renderer_pkg::*;
#(
  parameter int NUM_BLOCKS = 16,
  parameter int SLOTS      = 4,
  parameter int BLOCK_HALF = BLOCK_HALF_DEF
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          new_line_in,
  input  logic [9:0]                    next_y_in,
  input  logic [10:0]                   x_in,
  input  logic [9:0]                    y_in,
  input  logic                          active_in,
  output logic                          tbl_rd_out,
  output logic [$clog2(NUM_BLOCKS)-1:0] tbl_addr_out,
  input  logic [42:0]                   tbl_data_in,
  output logic [10:0]                   x_out,
  output logic [9:0]                    y_out,
  output logic [11:0]                   block_x_out,
  output logic [11:0]                   block_y_out,
  output logic [13:0]                   block_z_out,
  output logic                          block_color_out,
  output logic [2:0]                    block_direction_out,
  output logic                          block_visible_out,
  output logic                          scan_busy_out,
  output logic                          line_overflow_out
);

  localparam int AW = $clog2(NUM_BLOCKS);
  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int CW = $clog2(SLOTS + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_BLOCKS - 1);
  localparam logic [CW-1:0] SLOTS_C   = CW'(SLOTS);
  localparam logic [12:0]   HALF13    = 13'(BLOCK_HALF);

  scan_state_t state, state_nxt;
  logic [AW-1:0] addr_q;
  logic [9:0]    line_y_q;
  logic          rd_vld_q;
  logic          commit, commit_q;

  block_entry_t  entry_in;
  logic          qual;

  block_entry_t [SLOTS-1:0] sh_ent, sh_ent_nxt;
  logic [CW-1:0]            sh_cnt, sh_cnt_nxt;
  logic                     sh_ovf, sh_ovf_nxt;

  block_entry_t [SLOTS-1:0] act_ent;
  logic [SLOTS-1:0]         act_vld;

  logic [SLOTS-1:0]         slot_hit;
  logic [SLOTS-1:0][13:0]   slot_z;
  logic [IW-1:0]            win_idx;
  logic                     any_hit;

  assign entry_in      = block_entry_t'(tbl_data_in);
  assign tbl_addr_out  = addr_q;
  // commit_q stretches busy over the cycle the new list becomes live.
  assign scan_busy_out = (state != S_IDLE) || commit_q;

  // Scan sequencing; a new_line pulse in any state restarts from entry 0.
  always_comb begin
    state_nxt  = state;
    tbl_rd_out = 1'b0;
    commit     = 1'b0;
    case (state)
      S_IDLE: begin
        if (new_line_in) state_nxt = S_SCAN;
      end
      S_SCAN: begin
        tbl_rd_out = 1'b1;
        if (new_line_in)              state_nxt = S_SCAN;
        else if (addr_q == LAST_ADDR) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (new_line_in) begin
          state_nxt = S_SCAN;
        end else begin
          state_nxt = S_IDLE;
          commit    = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM state, read address, target line and read-data tag.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      line_y_q <= '0;
      rd_vld_q <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      commit_q <= commit;
      // Data from a read issued in the restart cycle belongs to the old line.
      rd_vld_q <= tbl_rd_out && !new_line_in;
      if (new_line_in) begin
        addr_q   <= '0;
        line_y_q <= next_y_in;
      end else if (state == S_SCAN) begin
        addr_q   <= addr_q + AW'(1);
      end
    end
  end

  assign qual = rd_vld_q && entry_in.visible &&
                span_hit({3'b000, line_y_q}, {1'b0, entry_in.y}, HALF13);

  // Append qualifying entries in table order; the slot after the last marks overflow.
  always_comb begin
    sh_ent_nxt = sh_ent;
    sh_cnt_nxt = sh_cnt;
    sh_ovf_nxt = sh_ovf;
    if (qual) begin
      if (sh_cnt < SLOTS_C) begin
        sh_ent_nxt[sh_cnt[IW-1:0]] = entry_in;
        sh_cnt_nxt                 = sh_cnt + CW'(1);
      end else begin
        sh_ovf_nxt = 1'b1;
      end
    end
  end

  // Shadow list being built for the upcoming line.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sh_ent <= '0;
      sh_cnt <= '0;
      sh_ovf <= 1'b0;
    end else if (new_line_in) begin
      sh_cnt <= '0;
      sh_ovf <= 1'b0;
    end else begin
      sh_ent <= sh_ent_nxt;
      sh_cnt <= sh_cnt_nxt;
      sh_ovf <= sh_ovf_nxt;
    end
  end

  // Active list: swapped in whole at commit, using the post-drain shadow.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      act_ent           <= '0;
      act_vld           <= '0;
      line_overflow_out <= 1'b0;
    end else if (commit) begin
      act_ent           <= sh_ent_nxt;
      line_overflow_out <= sh_ovf_nxt;
      for (int i = 0; i < SLOTS; i++) act_vld[i] <= (CW'(i) < sh_cnt_nxt);
    end
  end

  // Horizontal coverage per slot.
  for (genvar s = 0; s < SLOTS; s++) begin : g_slot
    assign slot_hit[s] = act_vld[s] && act_ent[s].visible &&
                         span_hit({2'b00, x_in}, {1'b0, act_ent[s].x}, HALF13);
    assign slot_z[s]   = act_ent[s].z;
  end

  zmin_select #(.SLOTS(SLOTS), .ZW(14), .IW(IW)) u_zmin (
    .hit     (slot_hit),
    .z       (slot_z),
    .win_idx (win_idx),
    .any_hit (any_hit)
  );

  // Registered pixel outputs; fields are zero whenever no block is shown.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      x_out               <= '0;
      y_out               <= '0;
      block_x_out         <= '0;
      block_y_out         <= '0;
      block_z_out         <= '0;
      block_color_out     <= 1'b0;
      block_direction_out <= '0;
      block_visible_out   <= 1'b0;
    end else begin
      x_out <= x_in;
      y_out <= y_in;
      if (active_in && any_hit) begin
        block_x_out         <= act_ent[win_idx].x;
        block_y_out         <= act_ent[win_idx].y;
        block_z_out         <= act_ent[win_idx].z;
        block_color_out     <= act_ent[win_idx].color;
        block_direction_out <= act_ent[win_idx].dir;
        block_visible_out   <= 1'b1;
      end else begin
        block_x_out         <= '0;
        block_y_out         <= '0;
        block_z_out         <= '0;
        block_color_out     <= 1'b0;
        block_direction_out <= '0;
        block_visible_out   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_block_line_scheduler.sv
// Directed bench: pixel probes push expected outputs into a scoreboard that a
// separate monitor drains one cycle later; scan control is checked inline.
module tb_block_line_scheduler;
  import renderer_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        new_line_in;
  logic [9:0]  next_y_in;
  logic [10:0] x_in;
  logic [9:0]  y_in;
  logic        active_in;
  logic        tbl_rd_out;
  logic [3:0]  tbl_addr_out;
  logic [42:0] tbl_data_in = '0;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic [11:0] block_x_out, block_y_out;
  logic [13:0] block_z_out;
  logic        block_color_out;
  logic [2:0]  block_direction_out;
  logic        block_visible_out;
  logic        scan_busy_out;
  logic        line_overflow_out;

  block_line_scheduler #(.NUM_BLOCKS(16), .SLOTS(4), .BLOCK_HALF(32)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .new_line_in(new_line_in),
    .next_y_in(next_y_in), .x_in(x_in), .y_in(y_in), .active_in(active_in),
    .tbl_rd_out(tbl_rd_out), .tbl_addr_out(tbl_addr_out), .tbl_data_in(tbl_data_in),
    .x_out(x_out), .y_out(y_out), .block_x_out(block_x_out), .block_y_out(block_y_out),
    .block_z_out(block_z_out), .block_color_out(block_color_out),
    .block_direction_out(block_direction_out), .block_visible_out(block_visible_out),
    .scan_busy_out(scan_busy_out), .line_overflow_out(line_overflow_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic        vis;
    logic [11:0] bx;
    logic [11:0] by;
    logic [13:0] bz;
    logic        col;
    logic [2:0]  dir;
    logic [10:0] xo;
    logic [9:0]  yo;
  } exp_t;

  block_entry_t tbl [16];
  exp_t         sb [$];
  exp_t         mexp, mgot;
  logic         probe = 1'b0;
  logic         probe_d = 1'b0;
  int           total = 0;
  int           bad = 0;

  // Block table model: one-cycle read latency.
  always @(posedge clk_in) if (tbl_rd_out) tbl_data_in <= tbl[tbl_addr_out];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  // Monitor: each probed pixel shows up one cycle after it was sampled.
  always @(posedge clk_in) probe_d <= probe;
  always @(negedge clk_in) begin
    if (probe_d) begin
      mgot = '{block_visible_out, block_x_out, block_y_out, block_z_out,
               block_color_out, block_direction_out, x_out, y_out};
      if (sb.size() == 0) begin
        check("sb_underflow", 64'd1, 64'd0);
      end else begin
        mexp = sb.pop_front();
        check("pixel", mgot, mexp);
      end
    end
  end

  function automatic block_entry_t mk(input int x, input int y, input int z,
                                      input int col, input int dir, input bit vis);
    block_entry_t e;
    e.x       = 12'(x);
    e.y       = 12'(y);
    e.z       = 14'(z);
    e.color   = color_t'(col[0]);
    e.dir     = direction_t'(dir[2:0]);
    e.visible = vis;
    return e;
  endfunction

  function automatic exp_t ehit(input int x, input int y, input int bx, input int by,
                                input int bz, input int col, input int dir);
    return '{1'b1, 12'(bx), 12'(by), 14'(bz), col[0], 3'(dir), 11'(x), 10'(y)};
  endfunction

  function automatic exp_t emiss(input int x, input int y);
    return '{1'b0, 12'd0, 12'd0, 14'd0, 1'b0, 3'd0, 11'(x), 10'(y)};
  endfunction

  task automatic clear_tbl();
    for (int i = 0; i < 16; i++) tbl[i] = '0;
  endtask

  // Called at a negedge; inputs are sampled at the next posedge.
  task automatic pix(input int x, input int y, input bit act, input exp_t e);
    x_in = 11'(x); y_in = 10'(y); active_in = act; probe = 1'b1;
    sb.push_back(e);
    @(negedge clk_in);
    probe = 1'b0;
  endtask

  task automatic start_line(input int y);
    new_line_in = 1'b1; next_y_in = 10'(y);
    @(negedge clk_in);
    new_line_in = 1'b0;
  endtask

  task automatic run_line(input int y);
    start_line(y);
    repeat (19) @(negedge clk_in);
  endtask

  initial begin
    rst_n_in = 1'b0; new_line_in = 1'b0; next_y_in = '0;
    x_in = 11'd5; y_in = 10'd7; active_in = 1'b1;
    clear_tbl();
    repeat (2) @(negedge clk_in);
    check("rst_rd", 64'(tbl_rd_out), 64'd0);
    check("rst_addr", 64'(tbl_addr_out), 64'd0);
    check("rst_busy", 64'(scan_busy_out), 64'd0);
    check("rst_vis", 64'(block_visible_out), 64'd0);
    check("rst_xout", 64'(x_out), 64'd0);
    check("rst_ovf", 64'(line_overflow_out), 64'd0);
    rst_n_in = 1'b1; active_in = 1'b0;
    @(negedge clk_in);

    // Single block, scan timing and horizontal edges.
    tbl[0] = mk(100, 200, 50, 1, 1, 1'b1);
    start_line(200);
    check("busy_t1", 64'(scan_busy_out), 64'd1);
    repeat (15) @(negedge clk_in);
    check("rd_t16", 64'(tbl_rd_out), 64'd1);
    @(negedge clk_in);
    check("rd_t17", 64'(tbl_rd_out), 64'd0);
    @(negedge clk_in);
    check("busy_t18", 64'(scan_busy_out), 64'd1);
    @(negedge clk_in);
    check("busy_t19", 64'(scan_busy_out), 64'd0);
    pix(100, 200, 1'b1, ehit(100, 200, 100, 200, 50, 1, 1));
    pix(133, 200, 1'b1, emiss(133, 200));
    pix(132, 200, 1'b1, ehit(132, 200, 100, 200, 50, 1, 1));
    pix(68, 200, 1'b1, ehit(68, 200, 100, 200, 50, 1, 1));
    pix(67, 200, 1'b1, emiss(67, 200));
    pix(100, 200, 1'b0, emiss(100, 200));
    check("ovf_single", 64'(line_overflow_out), 64'd0);

    // Vertical qualification edges.
    run_line(232); pix(100, 232, 1'b1, ehit(100, 232, 100, 200, 50, 1, 1));
    run_line(233); pix(100, 233, 1'b1, emiss(100, 233));
    run_line(168); pix(100, 168, 1'b1, ehit(100, 168, 100, 200, 50, 1, 1));
    run_line(167); pix(100, 167, 1'b1, emiss(100, 167));
    run_line(300); pix(100, 300, 1'b1, emiss(100, 300));
    tbl[0].visible = 1'b0;
    run_line(200); pix(100, 200, 1'b1, emiss(100, 200));

    // Depth ordering and tie-break.
    clear_tbl();
    tbl[0] = mk(300, 50, 80, 0, 0, 1'b1);
    tbl[3] = mk(300, 50, 40, 1, 3, 1'b1);
    run_line(50);
    pix(300, 50, 1'b1, ehit(300, 50, 300, 50, 40, 1, 3));
    pix(290, 50, 1'b1, ehit(290, 50, 300, 50, 40, 1, 3));
    tbl[0].z = 14'd40;
    run_line(50);
    pix(300, 50, 1'b1, ehit(300, 50, 300, 50, 40, 0, 0));

    // Overflow: six qualifiers, only the first four loaded.
    clear_tbl();
    for (int i = 0; i < 6; i++) tbl[i] = mk(100 + 100 * i, 100, 10 + i, i % 2, i % 4, 1'b1);
    run_line(100);
    check("ovf_set", 64'(line_overflow_out), 64'd1);
    pix(100, 100, 1'b1, ehit(100, 100, 100, 100, 10, 0, 0));
    pix(400, 100, 1'b1, ehit(400, 100, 400, 100, 13, 1, 3));
    pix(500, 100, 1'b1, emiss(500, 100));
    pix(600, 100, 1'b1, emiss(600, 100));
    for (int i = 1; i < 6; i++) tbl[i].visible = 1'b0;
    run_line(100);
    check("ovf_clr", 64'(line_overflow_out), 64'd0);
    pix(400, 100, 1'b1, emiss(400, 100));
    pix(100, 100, 1'b1, ehit(100, 100, 100, 100, 10, 0, 0));

    // Restart five cycles into a scan.
    clear_tbl();
    tbl[2] = mk(700, 100, 5, 1, 2, 1'b1);
    tbl[9] = mk(900, 400, 7, 0, 4, 1'b1);
    run_line(600);
    start_line(100);
    repeat (4) @(negedge clk_in);
    start_line(400);
    repeat (12) @(negedge clk_in);
    check("abort_busy_old", 64'(scan_busy_out), 64'd1);
    pix(700, 100, 1'b1, emiss(700, 100));
    pix(900, 400, 1'b1, emiss(900, 400));
    repeat (2) @(negedge clk_in);
    check("abort_busy_drain", 64'(scan_busy_out), 64'd1);
    @(negedge clk_in);
    check("abort_busy_commit", 64'(scan_busy_out), 64'd1);
    pix(900, 400, 1'b1, ehit(900, 400, 900, 400, 7, 0, 4));
    check("abort_busy_end", 64'(scan_busy_out), 64'd0);
    pix(700, 100, 1'b1, emiss(700, 100));

    // Asynchronous reset in the middle of a scan.
    clear_tbl();
    tbl[0] = mk(100, 200, 50, 1, 1, 1'b1);
    run_line(200);
    x_in = 11'd100; y_in = 10'd200; active_in = 1'b1;
    @(negedge clk_in);
    check("pre_rst_vis", 64'(block_visible_out), 64'd1);
    start_line(200);
    repeat (3) @(negedge clk_in);
    check("pre_rst_rd", 64'(tbl_rd_out), 64'd1);
    @(posedge clk_in);
    #2 rst_n_in = 1'b0;
    #1;
    check("arst_rd", 64'(tbl_rd_out), 64'd0);
    check("arst_busy", 64'(scan_busy_out), 64'd0);
    check("arst_vis", 64'(block_visible_out), 64'd0);
    check("arst_bx", 64'(block_x_out), 64'd0);
    check("arst_addr", 64'(tbl_addr_out), 64'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    pix(100, 200, 1'b1, emiss(100, 200));
    repeat (25) @(negedge clk_in);
    pix(100, 200, 1'b1, emiss(100, 200));
    run_line(200);
    pix(100, 200, 1'b1, ehit(100, 200, 100, 200, 50, 1, 1));

    repeat (3) @(negedge clk_in);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
